fp_add_sequencer: RTL and testbench
===================================

Name: fp_add_sequencer

Overview:
- Multi-cycle controller for the single-precision floating-point add/sub path.
- Sequences the stages in order: exponent compare, alignment right-shift, mantissa add/sub, iterative normalize, pack.
- Accepts one operation at a time over a valid/ready handshake and holds the result until it is consumed.
- Exports the per-operation alignment shift amount so the stage-2 shifter can be driven or monitored.

Parameters:
- MENT_WIDTH, 23, stored mantissa bits (hidden bit excluded).
- EXPO_WIDTH, 8, exponent bits; bias = 2^(EXPO_WIDTH-1)-1.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands present.
- in_ready  out  1  high only in IDLE.
- in_opa  in  1+EXPO_WIDTH+MENT_WIDTH  operand A, IEEE-754 layout.
- in_opb  in  1+EXPO_WIDTH+MENT_WIDTH  operand B.
- in_sub  in  1  1 = A-B, 0 = A+B.
- out_valid  out  1  result held valid (DONE state).
- out_ready  in  1  consumer accepts result.
- out_result  out  1+EXPO_WIDTH+MENT_WIDTH  packed result.
- out_flags  out  3  {invalid, overflow, underflow}.
- align_rshift  out  EXPO_WIDTH  exponent difference latched in EXP_CMP; saturates at all-ones.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; in_ready=1; out_valid=0; busy=0; out_result=0; out_flags=0; align_rshift=0. Reset mid-operation aborts immediately and discards the operation.
- Clock and reset are fixed: single clock, asynchronous active-low reset.
- Accept: in_valid & in_ready at edge E latches operands and in_sub (B sign inverted when in_sub=1); go to EXP_CMP.
- States and transitions: IDLE→EXP_CMP→ALIGN→ADD→NORM(1+k cycles)→PACK→DONE→IDLE.
- Latency: out_valid rises at edge E+5+k, where k = number of left normalize shifts.
- EXP_CMP:
  - Swap so that the larger magnitude is operand L (compare exponent, then mantissa).
  - align_rshift = expL - expS.
  - Exponent 0 (denormal) inputs are flushed to zero.
- ALIGN: mantissa S (hidden bit + guard/round/sticky extension) shifted right by align_rshift; a shift ≥ MENT_WIDTH+3 leaves only the sticky bit.
- ADD: signs equal → add, else L-S; the result sign is the sign of L.
- NORM, evaluated once per cycle:
  - Carry-out: shift right 1, exp+1, go to PACK.
  - Hidden bit set, or mantissa zero: go to PACK.
  - Otherwise: shift left 1, exp-1, stay in NORM.
  - Exponent reaching 0 while still unnormalized → result +0, underflow=1.
- PACK:
  - exp ≥ all-ones → ±inf, overflow=1.
  - Zero mantissa → +0.
  - Default rounding is truncation.
- Special inputs, resolved in EXP_CMP and sent straight to PACK:
  - Any NaN, or inf-inf of opposite effective sign → 0x7FC00000, invalid=1.
  - A single inf → that inf.
- DONE:
  - out_valid=1; out_result and out_flags are stable.
  - Leaves on out_valid & out_ready; the next operation may be accepted one cycle later (in_ready=0 during DONE).
  - out_valid and out_result hold while out_ready=0.
- in_valid outside IDLE is ignored; operands are not re-sampled.

Optional Feature:
- Macro FP_ADD_RNE_EN.
- Defined: PACK applies round-to-nearest-even using guard/round/sticky. Mantissa overflow from rounding increments exp (may raise overflow). PACK takes 1 extra cycle, so latency = 6+k.
- Undefined: truncation; latency = 5+k.

Test Plan:
- Reset mid-NORM: assert rst_n=0 during a 1.0-0.75 op → all outputs return to reset values immediately; a new op is accepted after release.
- 0x3F800000 + 0x3F800000 (1.0+1.0) → out_result=0x40000000, flags=0, align_rshift=0, out_valid at E+5.
- 0x3FC00000 + 0x3E800000 (1.5+0.25) → 0x3FE00000, align_rshift=2, latency 5.
- 0x3F800000 - 0x3F400000 (1.0-0.75) → 0x3E800000, k=2, latency 7. Separately, 0x3F800000 - 0x3F800000 → 0x00000000.
- 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000, overflow=1. 0x7F800000 - 0x7F800000 → 0x7FC00000, invalid=1.
- Backpressure: out_ready=0 for 10 cycles after out_valid → result held, in_ready=0; a back-to-back op is accepted on the cycle after the handshake.

Source files
------------

// File: rtl/fp_add_sequencer.sv
// rtl/fp_add_sequencer.sv - multi-cycle IEEE-754 add/sub sequencer (cmp, align, add, normalize, pack)
// Optional macro FP_ADD_RNE_EN: round-to-nearest-even in an extra PACK cycle; default truncates.
module fp_add_sequencer #(
  parameter int MENT_WIDTH = 23,
  parameter int EXPO_WIDTH = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [EXPO_WIDTH+MENT_WIDTH:0]   in_opa,
  input  logic [EXPO_WIDTH+MENT_WIDTH:0]   in_opb,
  input  logic                             in_sub,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [EXPO_WIDTH+MENT_WIDTH:0]   out_result,
  output logic [2:0]                       out_flags,
  output logic [EXPO_WIDTH-1:0]            align_rshift,
  output logic                             busy
);
  localparam int W  = 1 + EXPO_WIDTH + MENT_WIDTH;
  localparam int MW = MENT_WIDTH + 4;   // hidden + fraction + guard/round/sticky
  localparam int SW = MENT_WIDTH + 5;   // MW plus carry-out
  localparam logic [EXPO_WIDTH-1:0] EXP_MAX = '1;
  localparam logic [EXPO_WIDTH-1:0] SH_SAT  = EXPO_WIDTH'(MENT_WIDTH + 3);
  localparam logic [EXPO_WIDTH:0]   EXP_ONE = (EXPO_WIDTH+1)'(1);
  localparam logic [W-1:0] QNAN = {1'b0, EXP_MAX, 1'b1, {(MENT_WIDTH-1){1'b0}}};

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_EXP_CMP = 3'd1;
  localparam logic [2:0] S_ALIGN   = 3'd2;
  localparam logic [2:0] S_ADD     = 3'd3;
  localparam logic [2:0] S_NORM    = 3'd4;
  localparam logic [2:0] S_PACK    = 3'd5;
  localparam logic [2:0] S_RND     = 3'd6;
  localparam logic [2:0] S_DONE    = 3'd7;

  logic [2:0]            state;
  logic [W-1:0]          opa_r, opb_r, spec_res_r;
  logic                  sign_l, eff_sub, spec_r, inv_r, unf_r;
  logic [EXPO_WIDTH:0]   exp_r;
  logic [MW-1:0]         mant_l, mant_s;
  logic [SW-1:0]         sum_r;

  logic [EXPO_WIDTH-1:0] ea, eb;
  logic [MENT_WIDTH-1:0] fa, fb;
  logic [MENT_WIDTH:0]   ma, mb;
  logic                  a_nan, b_nan, a_inf, b_inf, a_is_l;
  logic                  special, special_inv;
  logic [W-1:0]          special_res;
  logic [MW-1:0]         shifted, shr_mask;
  logic [W-1:0]          pack_res;
  logic                  pack_ovf;

  assign in_ready  = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign out_valid = (state == S_DONE);

  // Denormals are flushed: a zero exponent drops both hidden bit and fraction.
  always_comb begin
    ea    = opa_r[W-2:MENT_WIDTH];
    eb    = opb_r[W-2:MENT_WIDTH];
    fa    = opa_r[MENT_WIDTH-1:0];
    fb    = opb_r[MENT_WIDTH-1:0];
    ma    = (ea == '0) ? '0 : {1'b1, fa};
    mb    = (eb == '0) ? '0 : {1'b1, fb};
    a_nan = (ea == EXP_MAX) && (fa != '0);
    b_nan = (eb == EXP_MAX) && (fb != '0);
    a_inf = (ea == EXP_MAX) && (fa == '0);
    b_inf = (eb == EXP_MAX) && (fb == '0);
    a_is_l = {ea, ma} >= {eb, mb};
  end

  always_comb begin
    special     = 1'b1;
    special_inv = 1'b0;
    special_res = QNAN;
    if (a_nan || b_nan || (a_inf && b_inf && (opa_r[W-1] != opb_r[W-1])))
      special_inv = 1'b1;
    else if (a_inf)
      special_res = {opa_r[W-1], EXP_MAX, {MENT_WIDTH{1'b0}}};
    else if (b_inf)
      special_res = {opb_r[W-1], EXP_MAX, {MENT_WIDTH{1'b0}}};
    else
      special = 1'b0;
  end

  // Right shift keeping everything shifted out as a sticky OR in bit 0.
  always_comb begin
    shr_mask = ~({MW{1'b1}} << align_rshift);
    if (align_rshift >= SH_SAT)
      shifted = {{(MW-1){1'b0}}, |mant_s};
    else
      shifted = (mant_s >> align_rshift) | {{(MW-1){1'b0}}, |(mant_s & shr_mask)};
  end

  always_comb begin
    pack_ovf = 1'b0;
    if (spec_r)
      pack_res = spec_res_r;
    else if (sum_r == '0)
      pack_res = '0;
    else if (exp_r >= {1'b0, EXP_MAX}) begin
      pack_res = {sign_l, EXP_MAX, {MENT_WIDTH{1'b0}}};
      pack_ovf = 1'b1;
    end else
      pack_res = {sign_l, exp_r[EXPO_WIDTH-1:0], sum_r[MENT_WIDTH+2:3]};
  end

`ifdef FP_ADD_RNE_EN
  logic                  rnd_inc;
  logic [MENT_WIDTH+1:0] rnd_m;
  always_comb begin
    rnd_inc = sum_r[2] & (sum_r[1] | sum_r[0] | sum_r[3]);
    rnd_m   = {1'b0, sum_r[MENT_WIDTH+3:3]} + {{(MENT_WIDTH+1){1'b0}}, rnd_inc};
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      opa_r        <= '0;
      opb_r        <= '0;
      spec_res_r   <= '0;
      sign_l       <= 1'b0;
      eff_sub      <= 1'b0;
      spec_r       <= 1'b0;
      inv_r        <= 1'b0;
      unf_r        <= 1'b0;
      exp_r        <= '0;
      mant_l       <= '0;
      mant_s       <= '0;
      sum_r        <= '0;
      align_rshift <= '0;
      out_result   <= '0;
      out_flags    <= '0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          opa_r  <= in_opa;
          opb_r  <= {in_opb[W-1] ^ in_sub, in_opb[W-2:0]};
          spec_r <= 1'b0;
          inv_r  <= 1'b0;
          unf_r  <= 1'b0;
          state  <= S_EXP_CMP;
        end
        S_EXP_CMP: begin
          sign_l       <= a_is_l ? opa_r[W-1] : opb_r[W-1];
          eff_sub      <= opa_r[W-1] ^ opb_r[W-1];
          exp_r        <= {1'b0, a_is_l ? ea : eb};
          mant_l       <= {a_is_l ? ma : mb, 3'b000};
          mant_s       <= {a_is_l ? mb : ma, 3'b000};
          align_rshift <= a_is_l ? (ea - eb) : (eb - ea);
          spec_r       <= special;
          spec_res_r   <= special_res;
          inv_r        <= special_inv;
          state        <= special ? S_PACK : S_ALIGN;
        end
        S_ALIGN: begin
          mant_s <= shifted;
          state  <= S_ADD;
        end
        S_ADD: begin
          sum_r <= eff_sub ? ({1'b0, mant_l} - {1'b0, mant_s})
                           : ({1'b0, mant_l} + {1'b0, mant_s});
          state <= S_NORM;
        end
        S_NORM: begin
          if (sum_r[SW-1]) begin
            sum_r <= {1'b0, sum_r[SW-1:2], sum_r[1] | sum_r[0]};
            exp_r <= exp_r + EXP_ONE;
            state <= S_PACK;
          end else if (sum_r[SW-2] || (sum_r == '0)) begin
            state <= S_PACK;
          end else if (exp_r <= EXP_ONE) begin
            // one more left shift would take the exponent to zero
            sum_r <= '0;
            exp_r <= '0;
            unf_r <= 1'b1;
            state <= S_PACK;
          end else begin
            sum_r <= sum_r << 1;
            exp_r <= exp_r - EXP_ONE;
          end
        end
        S_PACK: begin
`ifdef FP_ADD_RNE_EN
          if (!spec_r) begin
            if (rnd_m[MENT_WIDTH+1]) begin
              sum_r <= {2'b01, {(MENT_WIDTH+3){1'b0}}};
              exp_r <= exp_r + EXP_ONE;
            end else
              sum_r <= {1'b0, rnd_m[MENT_WIDTH:0], 3'b000};
          end
          state <= S_RND;
`else
          out_result <= pack_res;
          out_flags  <= {inv_r, pack_ovf, unf_r};
          state      <= S_DONE;
`endif
        end
        S_RND: begin
          out_result <= pack_res;
          out_flags  <= {inv_r, pack_ovf, unf_r};
          state      <= S_DONE;
        end
        S_DONE: if (out_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_add_sequencer.sv
// tb/tb_fp_add_sequencer.sv - scoreboard bench for fp_add_sequencer (default truncating build)
module tb_fp_add_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_sub = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_opa = '0;
  logic [31:0] in_opb = '0;
  logic        in_ready, out_valid, busy;
  logic [31:0] out_result;
  logic [2:0]  out_flags;
  logic [7:0]  align_rshift;

  fp_add_sequencer #(.MENT_WIDTH(23), .EXPO_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_opa(in_opa), .in_opb(in_opb), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_flags(out_flags), .align_rshift(align_rshift), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic [2:0]  flg;
    int          al;
    int          due;
    int          hold;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   last_hs = -100;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: exact integer arithmetic on the significands, truncated to 24 bits.
  function automatic void ref_add(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] res, output logic [2:0] flg,
                                  output int lat);
    int ea, eb, el, es, d, p, er;
    logic [63:0] ma, mb, ml, ms, r, mant;
    logic sl, sub;
    bit a_nan, b_nan, a_inf, b_inf;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    flg = 3'b000; lat = 5; res = 32'h0;
    a_nan = (ea == 255) && (a[22:0] != 0);
    b_nan = (eb == 255) && (b[22:0] != 0);
    a_inf = (ea == 255) && (a[22:0] == 0);
    b_inf = (eb == 255) && (b[22:0] == 0);
    if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31]))) begin
      res = 32'h7FC00000; flg = 3'b100; lat = 2; return;
    end
    if (a_inf) begin res = {a[31], 8'hFF, 23'h0}; lat = 2; return; end
    if (b_inf) begin res = {b[31], 8'hFF, 23'h0}; lat = 2; return; end
    ma = (ea == 0) ? 64'd0 : (64'(a[22:0]) | 64'h800000);
    mb = (eb == 0) ? 64'd0 : (64'(b[22:0]) | 64'h800000);
    if (ea > eb || (ea == eb && ma >= mb)) begin
      el = ea; es = eb; ml = ma; ms = mb; sl = a[31];
    end else begin
      el = eb; es = ea; ml = mb; ms = ma; sl = b[31];
    end
    sub = a[31] != b[31];
    if (ml == 0) return;
    if (ms == 0) begin res = {sl, 8'(el), ml[22:0]}; return; end
    d = el - es;
    if (d > 36) begin
      if (!sub) res = {sl, 8'(el), ml[22:0]};
      else if (ml[22:0] == 0) begin res = {sl, 8'(el - 1), 23'h7FFFFF}; lat = 6; end
      else res = {sl, 8'(el), ml[22:0] - 23'd1};
      return;
    end
    r = sub ? ((ml << d) - ms) : ((ml << d) + ms);
    if (r == 0) return;
    p = 0;
    for (int i = 0; i < 64; i++) if (r[i]) p = i;
    er = es + p - 23;
    if (er >= 255) begin res = {sl, 8'hFF, 23'h0}; flg = 3'b010; return; end
    if (er <= 0) begin flg = 3'b001; lat = 5 + el - 1; return; end
    mant = (p >= 23) ? (r >> (p - 23)) : (r << (23 - p));
    res = {sl, 8'(er), mant[22:0]};
    if (er < el) lat = 5 + el - er;
  endfunction

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sub,
                       input int hold, output int acc);
    exp_t e;
    int   n, lat, ea, eb;
    n = 0;
    acc = -1;
    @(negedge clk);
    while (!in_ready && n < 300) begin @(negedge clk); n++; end
    if (!in_ready) begin chk("accept_timeout", 0, 1); return; end
    in_opa = a; in_opb = b; in_sub = sub; in_valid = 1'b1;
    ref_add(a, {b[31] ^ sub, b[30:0]}, e.res, e.flg, lat);
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    e.al   = (ea > eb) ? ea - eb : eb - ea;
    e.due  = cyc + 1 + lat;
    e.hold = hold;
    acc    = cyc + 1;
    sb_q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0; in_opa = $urandom; in_opb = $urandom; in_sub = 1'($urandom_range(0, 1));
  endtask

  initial begin : monitor
    exp_t        e;
    logic [31:0] held;
    forever begin
      @(negedge clk);
      if (out_valid) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_out", 1, 0);
          out_ready = 1'b1;
          @(negedge clk);
          out_ready = 1'b0;
        end else begin
          e = sb_q.pop_front();
          chk("result", out_result, e.res);
          chk("flags", out_flags, e.flg);
          chk("align_rshift", align_rshift, e.al);
          chk("latency", cyc, e.due);
          held = out_result;
          for (int i = 0; i < e.hold; i++) begin
            @(negedge clk);
            chk("hold_valid", out_valid, 1);
            chk("hold_result", out_result, held);
            chk("hold_in_ready", in_ready, 0);
          end
          out_ready = 1'b1;
          @(negedge clk);
          out_ready = 1'b0;
          last_hs = cyc;
          chk("post_hs_valid", out_valid, 0);
          chk("post_hs_ready", in_ready, 1);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin : driver
    logic [31:0] a, b;
    int          mode, acc, n;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result", out_result, 0);
    chk("rst_flags", out_flags, 0);
    chk("rst_align", align_rshift, 0);
    rst_n = 1'b1;

    // Abort 1.0 - 0.75 while normalizing.
    @(negedge clk);
    in_opa = 32'h3F800000; in_opb = 32'h3F400000; in_sub = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("norm_busy", busy, 1);
    chk("norm_align", align_rshift, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_result", out_result, 0);
    chk("abort_flags", out_flags, 0);
    chk("abort_align", align_rshift, 0);
    @(negedge clk);
    rst_n = 1'b1;

    issue(32'h3F800000, 32'h3F800000, 1'b0, 0, acc);
    issue(32'h3FC00000, 32'h3E800000, 1'b0, 1, acc);
    issue(32'h3F800000, 32'h3F400000, 1'b1, 0, acc);
    issue(32'h3F800000, 32'h3F800000, 1'b1, 0, acc);
    issue(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 0, acc);
    issue(32'h7F800000, 32'h7F800000, 1'b1, 2, acc);
    issue(32'h40400000, 32'h3F800000, 1'b0, 10, acc);
    issue(32'hC0000000, 32'h3F800000, 1'b1, 0, acc);
    chk("b2b_accept", acc, last_hs + 1);
    issue(32'h00400000, 32'h3F800000, 1'b0, 0, acc);
    issue(32'h00800001, 32'h00800000, 1'b1, 0, acc);

    for (int t = 0; t < 40; t++) begin
      mode = $urandom_range(0, 5);
      a = $urandom;
      b = $urandom;
      case (mode)
        1: b[30:23] = 8'(a[30:23] + 8'($urandom_range(0, 2)));
        2: begin
          a[30:23] = 8'($urandom_range(0, 3));
          b[30:23] = 8'($urandom_range(0, 3));
        end
        3: begin
          a[30:23] = 8'($urandom_range(250, 254));
          b[30:23] = a[30:23];
          b[31]    = a[31];
        end
        4: begin
          b = a;
          b[3:0] = 4'($urandom);
        end
        5: a = {a[31], 8'hFF, (b[0] ? 23'h0 : a[22:0])};
        default: ;
      endcase
      issue(a, b, 1'($urandom_range(0, 1)), $urandom_range(0, 3), acc);
    end

    n = 0;
    while ((sb_q.size() != 0 || out_valid) && n < 1000) begin @(negedge clk); n++; end
    chk("drain", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
